// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, digit width and default wrap values
package stopwatch_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, PAUSE = 2'd1, ADJ_MIN = 2'd2, ADJ_SEC = 2'd3} state_t;
  localparam int DIGIT_W = 4;
  localparam int SEC_WRAP_DEF = 59;
  localparam int MIN_WRAP_DEF = 59;
endpackage

// File: rtl/stopwatch_bcd_pair_cnt.sv
// bcd_pair_cnt: two-digit BCD counter wrapping to 00 after WRAP, with a combinational carry on wrap
module bcd_pair_cnt
  import stopwatch_pkg::*;
#(
  parameter int WRAP = 59
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic               co
);
  localparam logic [DIGIT_W-1:0] WT = DIGIT_W'(WRAP / 10);
  localparam logic [DIGIT_W-1:0] WO = DIGIT_W'(WRAP % 10);
  localparam logic [DIGIT_W-1:0] NINE = DIGIT_W'(9);
  assign co = inc && tens == WT && ones == WO;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      ones <= (co || ones == NINE) ? '0 : ones + 1'b1;
      tens <= co ? '0 : (ones == NINE) ? tens + 1'b1 : tens;
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/adjust sequencing of an MM:SS BCD counter with adjust-digit blinking
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int SEC_WRAP  = SEC_WRAP_DEF,
  parameter int MIN_WRAP  = MIN_WRAP_DEF,
  parameter bit BLINK_ADJ = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1hz,
  input  logic               tick_2hz,
  input  logic               tick_blink,
  input  logic               pause_lvl,
  input  logic               adj_lvl,
  input  logic               sel_lvl,
  output logic [DIGIT_W-1:0] mt,
  output logic [DIGIT_W-1:0] mo,
  output logic [DIGIT_W-1:0] st,
  output logic [DIGIT_W-1:0] so,
  output logic [3:0]         blank,
  output logic [1:0]         mode,
  output logic               paused
);
  state_t state, state_n;
  logic pause_q, pause_pulse, paused_n, blink_phase;
  logic sec_inc, min_inc, sec_co, min_co_unused;
  assign pause_pulse = pause_lvl & ~pause_q;
  assign paused_n = paused ^ pause_pulse;
  assign mode = state;
  always_comb begin
    state_n = adj_lvl ? (sel_lvl ? ADJ_SEC : ADJ_MIN) : (paused_n ? PAUSE : RUN);
    sec_inc = (state == RUN && tick_1hz) || (state == ADJ_SEC && tick_2hz);
    min_inc = (state == RUN && sec_co) || (state == ADJ_MIN && tick_2hz);
  end
  // pause_q resets high so a button held across reset release is not seen as an edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= RUN;
      pause_q     <= 1'b1;
      paused      <= 1'b0;
      blink_phase <= 1'b0;
      blank       <= '0;
    end else begin
      state       <= state_n;
      pause_q     <= pause_lvl;
      paused      <= paused_n;
      blink_phase <= state[1] && (blink_phase ^ tick_blink);
      blank       <= (!BLINK_ADJ || !blink_phase) ? 4'b0000 :
                     state == ADJ_SEC ? 4'b0011 : state == ADJ_MIN ? 4'b1100 : 4'b0000;
    end
  bcd_pair_cnt #(.WRAP(SEC_WRAP)) u_sec (
    .clk(clk), .rst(rst), .inc(sec_inc), .tens(st), .ones(so), .co(sec_co)
  );
  bcd_pair_cnt #(.WRAP(MIN_WRAP)) u_min (
    .clk(clk), .rst(rst), .inc(min_inc), .tens(mt), .ones(mo), .co(min_co_unused)
  );
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of counting, pause, adjust, blink and async reset
module tb_stopwatch_ctrl;
  logic clk = 0, rst = 1;
  logic tick_1hz = 0, tick_2hz = 0, tick_blink = 0, pause_lvl = 0, adj_lvl = 0, sel_lvl = 0;
  logic [3:0] mt, mo, st, so, blank;
  logic [1:0] mode;
  logic paused;
  int tests = 0, fails = 0;

  stopwatch_ctrl dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_blink(tick_blink),
    .pause_lvl(pause_lvl), .adj_lvl(adj_lvl), .sel_lvl(sel_lvl),
    .mt(mt), .mo(mo), .st(st), .so(so), .blank(blank), .mode(mode), .paused(paused)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic t1(input int n);
    tick_1hz = 1; cyc(n); tick_1hz = 0;
  endtask

  task automatic t2(input int n);
    tick_2hz = 1; cyc(n); tick_2hz = 0;
  endtask

  task automatic press();
    pause_lvl = 1; cyc(); pause_lvl = 0; cyc();
  endtask

  task automatic blink();
    tick_blink = 1; cyc(); tick_blink = 0;
  endtask

  initial begin
    cyc(3);
    chk("rst_digits", {mt, mo, st, so}, 16'h0000);
    chk("rst_mode", 16'(mode), 16'd0);
    chk("rst_paused", 16'(paused), 16'd0);
    chk("rst_blank", 16'(blank), 16'd0);
    rst = 0;
    cyc();
    t1(61);
    chk("run_61", {mt, mo, st, so}, 16'h0101);
    chk("run_mode", 16'(mode), 16'd0);
    chk("run_paused", 16'(paused), 16'd0);
    chk("run_blank", 16'(blank), 16'd0);
    adj_lvl = 1; sel_lvl = 0; cyc();
    chk("adjmin_mode", 16'(mode), 16'd2);
    t2(58);
    chk("adjmin_58", {mt, mo, st, so}, 16'h5901);
    sel_lvl = 1; cyc();
    chk("adjsec_mode", 16'(mode), 16'd3);
    t2(57);
    chk("adjsec_57", {mt, mo, st, so}, 16'h5958);
    adj_lvl = 0; cyc();
    chk("exit_run", 16'(mode), 16'd0);
    t1(1);
    chk("run_5959", {mt, mo, st, so}, 16'h5959);
    t1(1);
    chk("hour_wrap", {mt, mo, st, so}, 16'h0000);
    t1(5);
    chk("run_0005", {mt, mo, st, so}, 16'h0005);
    pause_lvl = 1; cyc(); pause_lvl = 0;
    chk("pause_mode", 16'(mode), 16'd1);
    chk("pause_flag", 16'(paused), 16'd1);
    cyc();
    t1(10);
    chk("pause_hold", {mt, mo, st, so}, 16'h0005);
    pause_lvl = 1; cyc(); pause_lvl = 0;
    chk("resume_mode", 16'(mode), 16'd0);
    chk("resume_flag", 16'(paused), 16'd0);
    cyc();
    t1(1);
    chk("resume_tick", {mt, mo, st, so}, 16'h0006);
    press();
    chk("pause2_mode", 16'(mode), 16'd1);
    adj_lvl = 1; sel_lvl = 1; cyc();
    chk("padj_sec_mode", 16'(mode), 16'd3);
    t2(55);
    chk("adjsec_wrap", {mt, mo, st, so}, 16'h0001);
    sel_lvl = 0; cyc();
    t2(3);
    chk("adjmin_3", {mt, mo, st, so}, 16'h0301);
    adj_lvl = 0; cyc();
    chk("back_pause", 16'(mode), 16'd1);
    t1(20);
    chk("pause_hold2", {mt, mo, st, so}, 16'h0301);
    chk("pause_persist", 16'(paused), 16'd1);
    press();
    t1(9);
    chk("run_0310", {mt, mo, st, so}, 16'h0310);
    adj_lvl = 1; sel_lvl = 0; cyc();
    press();
    chk("adj_pause_mode", 16'(mode), 16'd2);
    chk("adj_pause_flag", 16'(paused), 16'd1);
    adj_lvl = 0; cyc();
    chk("adj_exit_pause", 16'(mode), 16'd1);
    t1(3);
    chk("frozen", {mt, mo, st, so}, 16'h0310);
    press();
    chk("run_again", 16'(mode), 16'd0);
    pause_lvl = 1; tick_1hz = 1; cyc(); pause_lvl = 0; tick_1hz = 0;
    chk("sim_tick", {mt, mo, st, so}, 16'h0311);
    chk("sim_mode", 16'(mode), 16'd1);
    cyc();
    press();
    adj_lvl = 1; sel_lvl = 0; cyc();
    blink();
    chk("blink_lat", 16'(blank), 16'd0);
    cyc();
    chk("blink_min_on", 16'(blank), 16'b1100);
    blink();
    cyc();
    chk("blink_min_off", 16'(blank), 16'b0000);
    blink();
    cyc();
    chk("blink_min_on2", 16'(blank), 16'b1100);
    adj_lvl = 0; cyc();
    chk("exit_mode", 16'(mode), 16'd0);
    cyc();
    chk("exit_blank", 16'(blank), 16'd0);
    adj_lvl = 1; sel_lvl = 1; cyc();
    blink();
    cyc();
    chk("blink_sec_on", 16'(blank), 16'b0011);
    adj_lvl = 0; cyc(2);
    chk("exit_blank2", 16'(blank), 16'd0);
    t1(4);
    chk("pre_rst", {mt, mo, st, so}, 16'h0315);
    #2 pause_lvl = 1; rst = 1;
    #1 chk("async_rst", {mt, mo, st, so}, 16'h0000);
    chk("async_mode", 16'(mode), 16'd0);
    cyc(2);
    rst = 0;
    cyc(3);
    chk("held_paused", 16'(paused), 16'd0);
    chk("held_mode", 16'(mode), 16'd0);
    pause_lvl = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
